mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). This is the step from the single-cycle core toward a multi-cycle core with variable-latency memory.
- Accepts one request at a time through a valid/ready handshake, issues it downstream and waits for the response. It then routes the response back to whichever requester owns the transaction.
- Fixed LSU priority, with a starvation guard for the IFU.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MAX_LSU_STREAK, 4, maximum number of consecutive LSU grants while the IFU is waiting; range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  in  1  IFU request valid
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_WIDTH  fetch address
- ifu_resp_valid  out  1  fetch data valid
- ifu_rdata  out  DATA_WIDTH  fetch data
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_WIDTH  load/store address
- lsu_we  in  1  1 = store
- lsu_wmask  in  DATA_WIDTH/8  byte write mask
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_resp_valid  out  1  load data valid, or store complete
- lsu_rdata  out  DATA_WIDTH  load data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepted
- mem_addr  out  ADDR_WIDTH  latched address
- mem_we  out  1  latched write enable; forced 0 for IFU transactions
- mem_wmask  out  DATA_WIDTH/8  latched mask; forced 0 for IFU transactions
- mem_wdata  out  DATA_WIDTH  latched store data
- mem_resp_valid  in  1  downstream response valid
- mem_rdata  in  DATA_WIDTH  downstream read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high, on rst): state=IDLE, owner=IFU, streak=0, latched fields=0.
  - While rst is high every output is 0, including both req_ready signals.
- States: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - Selection rule:
    - Only one requester valid: select it.
    - Both valid: select LSU if streak < MAX_LSU_STREAK, otherwise select IFU.
  - Only the selected requester sees req_ready=1, combinationally from state and valids. The other requester sees ready=0.
  - On handshake (valid & ready): latch addr, we, wmask, wdata and owner; go to ISSUE. Fields from the unselected requester are never latched.
  - Streak update at grant:
    - LSU granted while ifu_req_valid=1: streak+1, saturating at MAX_LSU_STREAK.
    - IFU granted, or LSU granted while ifu_req_valid=0: streak=0.
- ISSUE:
  - mem_req_valid=1; mem_* driven from the latched registers and held stable.
  - Stay in ISSUE until mem_req_ready=1, then go to WAIT.
  - mem_resp_valid in ISSUE is ignored, including when it arrives in the same cycle as mem_req_ready.
- WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid=1: the owner's resp_valid=1 for exactly that cycle, with rdata = mem_rdata (combinational pass-through, zero added latency). Then go to IDLE.
  - The non-owner's resp_valid stays 0.
  - For stores, lsu_rdata is don't-care, but lsu_resp_valid still pulses.
- Throughput: minimum 3 cycles per transaction (grant, issue, response). The IDLE cycle after a response is mandatory; there is no back-to-back grant from WAIT.
- mem_resp_valid in IDLE (e.g. a stale response after reset mid-transaction) is dropped: no resp_valid on either side, no state change.
- Reset during ISSUE or WAIT: the transaction is aborted with no response to the owner. The requester must re-issue.
- Requesters hold valid and payload stable until ready. The arbiter does not check this.

Test Plan:
- Single IFU fetch:
  - Stimulus: ifu_req_valid=1, addr=0x80000000; mem_req_ready=1 immediately; mem_resp_valid 2 cycles after issue with rdata=0x00100073.
  - Required: ifu_resp_valid pulses once with 0x00100073, mem_we=0, mem_wmask=0, busy low afterwards.
- Simultaneous requests:
  - Stimulus: IFU and LSU both valid in the same cycle; LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF.
  - Required: LSU granted first, mem_we=1, mem_wdata=0xDEADBEEF; IFU granted on the next IDLE.
- Starvation guard:
  - Stimulus: both requesters held valid continuously, MAX_LSU_STREAK=4.
  - Required: grant sequence is LSU,LSU,LSU,LSU,IFU, then repeats.
- Downstream backpressure:
  - Stimulus: mem_req_ready held low for 5 cycles.
  - Required: mem_req_valid=1 and mem_addr/mem_wdata unchanged for all 5 cycles; no new grant meanwhile.
- Reset mid-transaction:
  - Stimulus: assert rst in WAIT, deassert, then drive mem_resp_valid=1 in IDLE.
  - Required: all outputs 0 during reset; no resp_valid to either requester afterwards; the next request proceeds normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus shared by the IFU, LSU and downstream memory port.
// master drives request valid and payload and receives ready and response;
// slave is the opposite side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output req_valid, addr, we, wmask, wdata,
    input  req_ready, resp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, we, wmask, wdata,
    output req_ready, resp_valid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU: one outstanding transaction, LSU priority with IFU starvation guard.
// Latency: grant, issue and response take at least 3 cycles; response data is passed through combinationally.
// Backpressure: requesters are held off outside IDLE; the issued request is held stable until mem accepts it.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   ifu,
  mem_port_arbiter_if.slave   lsu,
  mem_port_arbiter_if.master  mem,
  output logic                busy
);

  localparam logic [3:0] MAX_STREAK = 4'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    owner_lsu;
  logic [3:0]              streak;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    pick_lsu;
  logic                    grant;

  // LSU wins whenever it asks, unless the IFU is waiting and the LSU streak is used up
  always_comb begin
    pick_lsu = lsu.req_valid && (!ifu.req_valid || (streak < MAX_STREAK));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, grant/ready and response routing; readies are gated by rst so
  // every output is quiet while reset is held
  always_comb begin
    state_nxt      = state;
    grant          = 1'b0;
    ifu.req_ready  = 1'b0;
    lsu.req_ready  = 1'b0;
    mem.req_valid  = 1'b0;
    ifu.resp_valid = 1'b0;
    lsu.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && (ifu.req_valid || lsu.req_valid)) begin
          grant         = 1'b1;
          lsu.req_ready = pick_lsu;
          ifu.req_ready = !pick_lsu;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        // a response arriving here is not ours yet and is ignored
        mem.req_valid = 1'b1;
        if (mem.req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem.resp_valid) begin
          ifu.resp_valid = !owner_lsu;
          lsu.resp_valid = owner_lsu;
          state_nxt      = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Latch the granted request; IFU transactions never write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wmask_q   <= '0;
      wdata_q   <= '0;
    end else if (grant) begin
      owner_lsu <= pick_lsu;
      if (pick_lsu) begin
        addr_q  <= lsu.addr;
        we_q    <= lsu.we;
        wmask_q <= lsu.wmask;
        wdata_q <= lsu.wdata;
      end else begin
        addr_q  <= ifu.addr;
        we_q    <= 1'b0;
        wmask_q <= '0;
        wdata_q <= '0;
      end
    end
  end

  // Count consecutive LSU grants that made a waiting IFU stand aside
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (grant) begin
      if (pick_lsu && ifu.req_valid) begin
        if (streak < MAX_STREAK) begin
          streak <= streak + 4'd1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

  // Downstream payload comes straight from the latched request
  always_comb begin
    mem.addr  = addr_q;
    mem.we    = we_q;
    mem.wmask = wmask_q;
    mem.wdata = wdata_q;
    busy      = (state != IDLE);
  end

  // Read data passes through to the owner only while its response is valid
  always_comb begin
    ifu.rdata = ifu.resp_valid ? mem.rdata : '0;
    lsu.rdata = lsu.resp_valid ? mem.rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random transactions
// against a transaction-level reference model (winner choice and LSU streak kept as plain integers).
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   errors   = 0;
  int   checks   = 0;
  int   streak_m = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifu_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) lsu_bus ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_LSU_STREAK(MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ifu (ifu_bus),
    .lsu (lsu_bus),
    .mem (mem_bus),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_no_resp(input string tag);
    chk({tag, "_ifu_resp"}, {31'd0, ifu_bus.resp_valid}, 32'd0);
    chk({tag, "_lsu_resp"}, {31'd0, lsu_bus.resp_valid}, 32'd0);
  endtask

  task automatic chk_issue(input string tag, input logic [31:0] ea, input logic ewe,
                           input logic [3:0] em, input logic [31:0] ewd, input bit own_lsu);
    chk({tag, "_memv"},  {31'd0, mem_bus.req_valid}, 32'd1);
    chk({tag, "_addr"},  mem_bus.addr, ea);
    chk({tag, "_we"},    {31'd0, mem_bus.we}, {31'd0, ewe});
    chk({tag, "_wmask"}, {28'd0, mem_bus.wmask}, {28'd0, em});
    if (own_lsu) chk({tag, "_wdata"}, mem_bus.wdata, ewd);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd1);
    chk({tag, "_irdy"},  {31'd0, ifu_bus.req_ready}, 32'd0);
    chk({tag, "_lrdy"},  {31'd0, lsu_bus.req_ready}, 32'd0);
    chk_no_resp(tag);
  endtask

  // One full transaction from an IDLE cycle back to IDLE. Called at posedge+1.
  task automatic txn(input string tag,
                     input bit iv, input logic [31:0] ia,
                     input bit lv, input logic [31:0] la, input logic lwe,
                     input logic [3:0] lm, input logic [31:0] lwd,
                     input int stall, input int lat, input logic [31:0] rd,
                     output bit got_lsu);
    bit exp_lsu;
    logic [31:0] ea;
    logic ewe;
    logic [3:0] em;
    exp_lsu = lv && (!iv || streak_m < MAX);
    ea  = exp_lsu ? la : ia;
    ewe = exp_lsu ? lwe : 1'b0;
    em  = exp_lsu ? lm : 4'h0;

    // IDLE: present the requests
    ifu_bus.req_valid  = iv;
    ifu_bus.addr       = ia;
    lsu_bus.req_valid  = lv;
    lsu_bus.addr       = la;
    lsu_bus.we         = lwe;
    lsu_bus.wmask      = lm;
    lsu_bus.wdata      = lwd;
    mem_bus.req_ready  = 1'b0;
    mem_bus.resp_valid = 1'b0;
    #1;
    got_lsu = lsu_bus.req_ready;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_memv"}, {31'd0, mem_bus.req_valid}, 32'd0);
    chk({tag, "_idle_irdy"}, {31'd0, ifu_bus.req_ready}, {31'd0, !exp_lsu});
    chk({tag, "_idle_lrdy"}, {31'd0, lsu_bus.req_ready}, {31'd0, exp_lsu});
    @(posedge clk); #1;

    if (exp_lsu) streak_m = iv ? ((streak_m < MAX) ? streak_m + 1 : MAX) : 0;
    else         streak_m = 0;
    if (exp_lsu) lsu_bus.req_valid = 1'b0;
    else         ifu_bus.req_valid = 1'b0;
    // the loser keeps its request up; scramble the winner's payload to prove it was latched
    if (exp_lsu) begin lsu_bus.addr = $urandom; lsu_bus.wdata = $urandom; end
    else         ifu_bus.addr = $urandom;

    // ISSUE with downstream backpressure; a stray response here must be ignored
    for (int s = 0; s < stall; s++) begin
      mem_bus.req_ready  = 1'b0;
      mem_bus.resp_valid = (s == 0);
      mem_bus.rdata      = $urandom;
      #1;
      chk_issue({tag, "_stall"}, ea, ewe, em, lwd, exp_lsu);
      @(posedge clk); #1;
    end
    mem_bus.req_ready  = 1'b1;
    mem_bus.resp_valid = 1'b1;
    mem_bus.rdata      = $urandom;
    #1;
    chk_issue({tag, "_issue"}, ea, ewe, em, lwd, exp_lsu);
    @(posedge clk); #1;

    // WAIT
    mem_bus.req_ready  = 1'b0;
    mem_bus.resp_valid = 1'b0;
    for (int w = 0; w < lat - 1; w++) begin
      #1;
      chk({tag, "_wait_memv"}, {31'd0, mem_bus.req_valid}, 32'd0);
      chk({tag, "_wait_busy"}, {31'd0, busy}, 32'd1);
      chk_no_resp({tag, "_wait"});
      @(posedge clk); #1;
    end
    mem_bus.resp_valid = 1'b1;
    mem_bus.rdata      = rd;
    #1;
    chk({tag, "_resp_ifu"}, {31'd0, ifu_bus.resp_valid}, {31'd0, !exp_lsu});
    chk({tag, "_resp_lsu"}, {31'd0, lsu_bus.resp_valid}, {31'd0, exp_lsu});
    chk({tag, "_resp_irdy"}, {31'd0, ifu_bus.req_ready}, 32'd0);
    chk({tag, "_resp_lrdy"}, {31'd0, lsu_bus.req_ready}, 32'd0);
    if (!exp_lsu)  chk({tag, "_ifu_rdata"}, ifu_bus.rdata, rd);
    else if (!lwe) chk({tag, "_lsu_rdata"}, lsu_bus.rdata, rd);
    @(posedge clk); #1;
    mem_bus.resp_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    bit iv, lv, lwe;
    logic [31:0] ia, la, lwd, rd;
    logic [3:0] lm;

    // Reset with every input active: all outputs must be 0
    rst = 1'b1;
    ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h1234_5678;
    ifu_bus.we = 1'b0; ifu_bus.wmask = 4'h0; ifu_bus.wdata = 32'h0;
    lsu_bus.req_valid = 1'b1; lsu_bus.addr = 32'h8765_4321;
    lsu_bus.we = 1'b1; lsu_bus.wmask = 4'hF; lsu_bus.wdata = 32'hFFFF_FFFF;
    mem_bus.req_ready = 1'b1; mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'hFFFF_FFFF;
    #1;
    chk("rst_irdy",  {31'd0, ifu_bus.req_ready}, 32'd0);
    chk("rst_lrdy",  {31'd0, lsu_bus.req_ready}, 32'd0);
    chk("rst_memv",  {31'd0, mem_bus.req_valid}, 32'd0);
    chk("rst_addr",  mem_bus.addr, 32'd0);
    chk("rst_we",    {31'd0, mem_bus.we}, 32'd0);
    chk("rst_wmask", {28'd0, mem_bus.wmask}, 32'd0);
    chk("rst_wdata", mem_bus.wdata, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk_no_resp("rst");
    chk("rst_irdata", ifu_bus.rdata, 32'd0);
    chk("rst_lrdata", lsu_bus.rdata, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    ifu_bus.req_valid = 1'b0; lsu_bus.req_valid = 1'b0;
    mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0;
    streak_m = 0;

    // Single IFU fetch
    txn("fetch", 1, 32'h8000_0000, 0, 32'h0, 0, 4'h0, 32'h0, 0, 2, 32'h0010_0073, got);
    #1 chk("fetch_busy_after", {31'd0, busy}, 32'd0);

    // Simultaneous requests: LSU store first, IFU on the following IDLE
    txn("simul_lsu", 1, 32'h8000_0040, 1, 32'h8000_1000, 1, 4'hF, 32'hDEAD_BEEF, 0, 1, 32'h0, got);
    chk("simul_first_lsu", {31'd0, got}, 32'd1);
    txn("simul_ifu", 1, 32'h8000_0040, 0, 32'h0, 0, 4'h0, 32'h0, 0, 1, 32'h0000_0013, got);
    chk("simul_second_ifu", {31'd0, got}, 32'd0);

    // Downstream backpressure for 5 cycles with the IFU waiting
    txn("bp", 1, 32'h8000_0080, 1, 32'h8000_2000, 1, 4'h3, 32'h1234_5678, 5, 1, 32'h0, got);

    // Starvation guard: clear the streak with an IFU grant, then both held valid
    txn("pre_starve", 1, 32'h8000_00C0, 0, 32'h0, 0, 4'h0, 32'h0, 0, 1, 32'h1, got);
    for (int i = 0; i < 10; i++) begin
      txn("starve", 1, 32'h8000_0100 + 32'(i * 4), 1, 32'h8000_3000 + 32'(i * 4), 0, 4'h0,
          32'h0, 0, 1, 32'hA000_0000 + 32'(i), got);
      chk("starve_seq", {31'd0, got}, {31'd0, (i % 5) != 4});
    end

    // Reset in WAIT, then a stale response in IDLE
    ifu_bus.req_valid = 1'b1; ifu_bus.addr = 32'h8000_0200;
    lsu_bus.req_valid = 1'b0;
    #1; @(posedge clk); #1;
    ifu_bus.req_valid = 1'b0; mem_bus.req_ready = 1'b1;
    #1; @(posedge clk); #1;
    mem_bus.req_ready = 1'b0;
    #1 chk("mid_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    ifu_bus.req_valid = 1'b1; lsu_bus.req_valid = 1'b1;
    mem_bus.resp_valid = 1'b1; mem_bus.rdata = 32'h5555_AAAA;
    #1;
    chk("mid_rst_irdy", {31'd0, ifu_bus.req_ready}, 32'd0);
    chk("mid_rst_lrdy", {31'd0, lsu_bus.req_ready}, 32'd0);
    chk("mid_rst_memv", {31'd0, mem_bus.req_valid}, 32'd0);
    chk("mid_rst_addr", mem_bus.addr, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk_no_resp("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    streak_m = 0;
    ifu_bus.req_valid = 1'b0; lsu_bus.req_valid = 1'b0;
    mem_bus.resp_valid = 1'b1;
    #1;
    chk_no_resp("stale");
    chk("stale_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk_no_resp("stale2");
    chk("stale2_busy", {31'd0, busy}, 32'd0);
    mem_bus.resp_valid = 1'b0;
    txn("after_rst", 1, 32'h8000_0200, 0, 32'h0, 0, 4'h0, 32'h0, 0, 2, 32'h0000_0297, got);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      iv  = $urandom_range(0, 1);
      lv  = $urandom_range(0, 1);
      if (!iv && !lv) iv = 1'b1;
      ia  = $urandom; la = $urandom; lwe = $urandom_range(0, 1);
      lm  = 4'($urandom); lwd = $urandom; rd = $urandom;
      txn("rand", iv, ia, lv, la, lwe, lm, lwd, $urandom_range(0, 3), $urandom_range(1, 3), rd, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
